// File: rtl/py_sco_pkg.sv
// Shared constants, typedefs and width helpers for the SCO ping-pong receive buffer.
package py_sco_pkg;

    localparam int unsigned SCO_NCH_MAX   = 4;
    localparam int unsigned SCO_DEPTH_MIN = 4;

    typedef logic [$clog2(SCO_NCH_MAX)-1:0] sco_ch_t;
    typedef int unsigned                    sco_width_t;

    // Channel index width; a single channel still gets one select bit.
    function automatic sco_width_t sco_ch_w(input int unsigned nch);
        return (nch > 1) ? sco_width_t'($clog2(nch)) : sco_width_t'(1);
    endfunction

    // Level counter width: must hold the value DEPTH itself.
    function automatic sco_width_t sco_lvl_w(input int unsigned depth);
        return sco_width_t'($clog2(depth)) + sco_width_t'(1);
    endfunction

endpackage

// File: rtl/py_sco_bank_mem.sv
// Two-bank, multi-channel voice word store: one synchronous write port, one registered read port.
module py_sco_bank_mem #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/py_sco_pingpong_buf.sv
// SCO/eSCO ping-pong receive buffer; banks exchange on every tsco_p slot pulse.
// Optional erroneous-packet marking is enabled by defining PY_SCO_ERRMARK_EN.
module py_sco_pingpong_buf
    import py_sco_pkg::*;
#(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 64,
    parameter  int unsigned NCH   = 2,
    localparam int unsigned CW    = sco_ch_w(NCH),
    localparam int unsigned LW    = sco_lvl_w(DEPTH)
) (
    input  logic           clk_6M,
    input  logic           rstz,
    input  logic           tsco_p,
    input  logic           wr_vld,
    input  logic [CW-1:0]  wr_ch,
    input  logic [DW-1:0]  wr_data,
`ifdef PY_SCO_ERRMARK_EN
    input  logic           wr_err,
    output logic           rd_bad,
`endif
    input  logic           rd_req,
    input  logic [CW-1:0]  rd_ch,
    output logic [DW-1:0]  rd_data,
    output logic           rd_vld,
    output logic           rd_udf,
    output logic [LW-1:0]  rd_level,
    output logic [NCH-1:0] ovf,
    input  logic [NCH-1:0] ovf_clr
);

    localparam int unsigned PW = LW - 1;
    localparam int unsigned AW = 1 + CW + PW;

    logic           bsel_q, bsel_d;
    logic [LW-1:0]  wptr_q [NCH];
    logic [LW-1:0]  wptr_d [NCH];
    logic [LW-1:0]  rptr_q [NCH];
    logic [LW-1:0]  rptr_d [NCH];
    logic [LW-1:0]  rcnt_q [NCH];
    logic [LW-1:0]  rcnt_d [NCH];
    logic [NCH-1:0] ovf_q, ovf_d;
    logic           rd_vld_q, rd_vld_d;
    logic           rd_udf_q, rd_udf_d;
`ifdef PY_SCO_ERRMARK_EN
    logic [NCH-1:0] wbad_q, wbad_d, rbad_q, rbad_d;
`endif

    logic           wr_hit, rd_hit, wr_full, wr_en, rd_en;
    logic [CW-1:0]  wch, rch;
    logic [AW-1:0]  waddr, raddr;

    // Out-of-range channels are steered to index 0 and masked by the hit flags.
    always_comb begin : access_decode
        wr_hit  = 32'(wr_ch) < NCH;
        rd_hit  = 32'(rd_ch) < NCH;
        wch     = wr_hit ? wr_ch : '0;
        rch     = rd_hit ? rd_ch : '0;
        wr_full = wptr_q[wch] == LW'(DEPTH);
        wr_en   = wr_vld & wr_hit & ~wr_full;
        rd_en   = rd_req & ~tsco_p & rd_hit & (rptr_q[rch] < rcnt_q[rch]);
        waddr   = {bsel_q, wch, wptr_q[wch][PW-1:0]};
        raddr   = {~bsel_q, rch, rptr_q[rch][PW-1:0]};
    end

    always_comb begin : next_state
        bsel_d   = bsel_q ^ tsco_p;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rcnt_d   = rcnt_q;
        ovf_d    = ovf_q & ~ovf_clr;
        rd_vld_d = rd_en;
        rd_udf_d = rd_req & ~tsco_p & ~rd_en;
`ifdef PY_SCO_ERRMARK_EN
        wbad_d   = wbad_q;
        rbad_d   = rbad_q;
        if (wr_en && wr_err) wbad_d[wch] = 1'b1;
`endif
        if (wr_en) wptr_d[wch] = wptr_q[wch] + LW'(1);
        if (wr_vld && wr_hit && wr_full) ovf_d[wch] = 1'b1;
        if (rd_en) rptr_d[rch] = rptr_q[rch] + LW'(1);
        // The swap-cycle write is already folded into wptr_d before it becomes rcnt.
        if (tsco_p) begin
            for (int c = 0; c < NCH; c++) begin
                rcnt_d[c] = wptr_d[c];
                wptr_d[c] = '0;
                rptr_d[c] = '0;
            end
`ifdef PY_SCO_ERRMARK_EN
            rbad_d = wbad_d;
            wbad_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            bsel_q   <= 1'b0;
            wptr_q   <= '{default: '0};
            rptr_q   <= '{default: '0};
            rcnt_q   <= '{default: '0};
            ovf_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_udf_q <= 1'b0;
`ifdef PY_SCO_ERRMARK_EN
            wbad_q   <= '0;
            rbad_q   <= '0;
`endif
        end else begin
            bsel_q   <= bsel_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rcnt_q   <= rcnt_d;
            ovf_q    <= ovf_d;
            rd_vld_q <= rd_vld_d;
            rd_udf_q <= rd_udf_d;
`ifdef PY_SCO_ERRMARK_EN
            wbad_q   <= wbad_d;
            rbad_q   <= rbad_d;
`endif
        end
    end

    py_sco_bank_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i   (clk_6M),
        .rst_n_i (rstz),
        .we_i    (wr_en),
        .waddr_i (waddr),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (rd_data)
    );

    always_comb begin : status_out
        rd_vld   = rd_vld_q;
        rd_udf   = rd_udf_q;
        ovf      = ovf_q;
        rd_level = rd_hit ? (rcnt_q[rch] - rptr_q[rch]) : '0;
`ifdef PY_SCO_ERRMARK_EN
        rd_bad   = rd_hit & rbad_q[rch];
`endif
    end

endmodule
